// File: rtl/clause_serializer_pkg.sv
// Shared types and constants for the clause serializer.
// Holds the default clause width and the FSM encoding.
package clause_serializer_pkg;

  localparam int CLAUSE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // One right shift with a zero entering at the MSB.
  function automatic logic [CLAUSE_W-1:0] shr1(
    input logic [CLAUSE_W-1:0] v
  );
    return {1'b0, v[CLAUSE_W-1:1]};
  endfunction

endpackage

// File: rtl/clause_serializer.sv
// Parallel-to-serial clause transmitter, LSB first.
// Mirrors the receiver's MSB-insert, right-shift register.
module clause_serializer
  import clause_serializer_pkg::*;
#(
  parameter int N  = CLAUSE_W,
  parameter int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         stall,
  output logic         sout,
  output logic         shift_en,
  output logic         busy,
  output logic         done
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e          state_q;
  logic [N-1:0]    data_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;

  // Handshake and strobe follow the state directly.
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q == SHIFT);
    shift_en = (state_q == SHIFT) && !stall;
    sout     = data_q[0];
    done     = done_q;
  end

  // Accept a word, then shift one bit per unstalled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!stall) begin
            data_q <= {1'b0, data_q[N-1:1]};
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_serializer.sv
// Self-checking bench for clause_serializer.
// Word-level model plus a receiver shift register.
module tb_clause_serializer;
  import clause_serializer_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         stall = 1'b0;
  logic         sout;
  logic         shift_en;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail = 0;

  clause_serializer #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .stall    (stall),
    .sout     (sout),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: word in flight and index of the bit on the line.
  logic         started = 1'b0;
  logic         m_busy = 1'b0;
  logic [N-1:0] m_word = '0;
  int           m_idx = 0;
  logic         m_done = 1'b0;
  logic [N-1:0] rx = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy  = 1'b0;
      m_word  = '0;
      m_idx   = 0;
      m_done  = 1'b0;
      rx      = '0;
      started = 1'b1;
    end else begin
      if (shift_en) rx = {sout, rx[N-1:1]};
      m_done = 1'b0;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_word = in_data;
          m_idx  = 0;
        end
      end else if (!stall) begin
        m_idx++;
        if (m_idx == N) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started && !reset) begin
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("busy", 32'(busy), 32'(m_busy));
      check("shift_en", 32'(shift_en), 32'(m_busy && !stall));
      check("sout", 32'(sout),
            32'(m_busy ? m_word[m_idx] : 1'b0));
      check("done", 32'(done), 32'(m_done));
      if (m_done) check("rx_word", 32'(rx), 32'(m_word));
    end
  end

  // Sends one word from idle; optional stall and busy-time data change.
  task automatic run_word(input logic [N-1:0] d,
                          input int stall_bit,
                          input int stall_len,
                          input logic [N-1:0] alt,
                          output logic [N-1:0] bits,
                          output int done_cyc,
                          output logic [N-1:0] rx_done);
    int nbit;
    int held;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = alt;
    bits = '0;
    done_cyc = -1;
    rx_done = '0;
    nbit = 0;
    held = 0;
    for (int c = 1; c <= 14; c++) begin
      stall = (nbit == stall_bit) && (held < stall_len);
      @(negedge clk);
      if (shift_en && nbit < N) begin
        bits[nbit] = sout;
        nbit++;
      end
      if (done && done_cyc < 0) begin
        done_cyc = c;
        rx_done  = rx;
      end
      @(posedge clk); #1;
      if (stall) held++;
    end
    stall = 1'b0;
  endtask

  logic [N-1:0] bits;
  int           dc;
  logic [N-1:0] rxd;
  int           seen;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(in_ready), 32'h1);
      check("idle_sout", 32'(sout), 32'h0);
    end
    @(posedge clk); #1;

    run_word(8'hA5, -1, 0, 8'hA5, bits, dc, rxd);
    check("a5_bits", 32'(bits), 32'hA5);
    check("a5_done_cyc", 32'(dc), 32'd9);
    check("a5_rx", 32'(rxd), 32'hA5);

    run_word(8'hA5, 3, 2, 8'hA5, bits, dc, rxd);
    check("a5s_bits", 32'(bits), 32'hA5);
    check("a5s_done_cyc", 32'(dc), 32'd11);
    check("a5s_rx", 32'(rxd), 32'hA5);

    run_word(8'h0F, -1, 0, 8'hF0, bits, dc, rxd);
    check("0f_bits", 32'(bits), 32'h0F);
    check("0f_rx", 32'(rxd), 32'h0F);

    // Back-to-back with in_valid held.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(posedge clk); #1;
    in_data = 8'hC3;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        check("b2b_ready", 32'(in_ready), 32'h1);
        check("b2b_rx1", 32'(rx), 32'h3C);
      end
      @(posedge clk); #1;
    end
    check("b2b_first_done", 32'(seen), 32'h1);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_busy2", 32'(busy), 32'h1);
    check("b2b_sout0", 32'(sout), 32'h1);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        check("b2b_rx2", 32'(rx), 32'hC3);
      end
    end
    check("b2b_second_done", 32'(seen), 32'h1);
    @(posedge clk); #1;

    // Reset during bit 4 of 8'hFF.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'h1);
    check("rst_shift_en", 32'(shift_en), 32'h0);
    check("rst_sout", 32'(sout), 32'h0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("rst_no_done", 32'(seen), 32'h0);
    @(posedge clk); #1;

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = N'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clause_serializer.md
Name: clause_serializer

Overview:
- Parallel-to-serial transmitter for clause data: accepts one N-bit clause word over a valid/ready handshake.
- Streams the word out LSB-first on a single serial line, with a qualifying shift strobe.
- Outputs drive the serial-in and shift-enable inputs of the clause-storage shift registers, which insert at the MSB and shift right. After N strobes the receiver therefore holds the word bit-for-bit.
- Sits between the clause-loading controller and the clause-storage shift-register chain.

Parameters:
- N, 8, clause word width in bits; must be >= 2.
- CW, $clog2(N), bit counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N  clause word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  serializer can accept a word this cycle.
- stall  input  1  hold transmission; no bit is emitted while high.
- sout  output  1  current serial bit; connects to receiver sin.
- shift_en  output  1  strobe: receiver samples sout this cycle; connects to receiver load.
- busy  output  1  a word is in transmission.
- done  output  1  one-cycle pulse after the last bit of a word is emitted.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-high, sampled only on the rising edge of clk.
  - Reset takes priority over all other inputs.
  - Reset state: state=IDLE, data register=0, bit counter=0, done=0.
  - Resulting outputs: in_ready=1, busy=0, shift_en=0, sout=0.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE); combinational.
- busy = (state==SHIFT).
- shift_en = (state==SHIFT) && !stall; combinational.
- sout = data_reg[0] in every state; it is 0 in IDLE after reset or after a completed word.
- IDLE:
  - On an edge with in_valid && in_ready: data_reg<=in_data, count<=0, state->SHIFT.
  - in_valid without in_ready is ignored; the upstream must hold data until accepted.
- SHIFT, on each edge with shift_en=1:
  - data_reg <= {1'b0, data_reg[N-1:1]}.
  - count <= count+1.
  - If count==N-1: state->IDLE, count<=0, done<=1 for exactly the next cycle.
- SHIFT, on an edge with stall=1: data_reg, count and state hold; shift_en=0.
  - stall may assert on any cycle, including the first or the last bit.
- Latency:
  - Word accepted at edge k; first bit is valid during cycle k+1.
  - With no stall, bits 0..N-1 occupy cycles k+1..k+N.
  - done and in_ready are both high in cycle k+N+1.
- Throughput: the next word can be accepted at the edge ending cycle k+N+1, so there is one idle cycle per word.
- done: registered; clears after one cycle unless another word completes, which is impossible back-to-back given the idle cycle.
- stall in IDLE has no effect.
- Reset mid-transmission: the word is abandoned and shift_en drops in the cycle after the reset edge. No done is emitted for the partial word. The receiver is expected to be reset alongside.
- in_data changes while busy are ignored.

Decomposition:
- Shared include header: default clause width constant; state encodings IDLE=1'b0, SHIFT=1'b1.
- No sub-module needed. The data path is an internal right-shifting register: the transmit-side mirror of the clause shift register.
- Bench may instantiate the existing clause shift register as the receiver to check end-to-end transfer.

Test Plan:
- Reset, then idle with in_valid=0 -> in_ready=1, busy=0, shift_en=0, sout=0, done=0 for 5 cycles.
- N=8, in_data=8'hA5 accepted at edge k -> sout=1,0,1,0,0,1,0,1 in cycles k+1..k+8 with shift_en=1; done=1 only in cycle k+9; receiver q==8'hA5.
- Same 8'hA5 transfer with stall=1 during bit 3 for 2 cycles -> shift_en=0 and sout held at bit 3 value (0) for those cycles; done at k+11; receiver q==8'hA5.
- in_valid held high with 8'h3C then 8'hC3 -> 8'h3C serialized, one idle cycle with in_ready=1, then 8'hC3 accepted; receiver q==8'hC3 after second done.
- reset asserted during bit 4 of 8'hFF -> next cycle in_ready=1, shift_en=0, sout=0, no done pulse.
- in_data toggled while busy (8'h0F sent, in_data driven to 8'hF0) -> serial output still 1,1,1,1,0,0,0,0.
